// File: rtl/bubble_pkg.sv
`default_nettype none
// ============================================================================
// Package  : bubble_pkg
// Brief    : Shared sizes, colour codes and state/direction types for the
//            bubble shooter grid and its joystick controller.
// Revision : 1.0 - initial release
// ============================================================================
package bubble_pkg;

    localparam int NUM_COLS = 8;
    localparam int COL_W    = 3;
    localparam int CELL_W   = 5;

    localparam logic [CELL_W-1:0] RED   = 5'd16;
    localparam logic [CELL_W-1:0] GREEN = 5'd17;
    localparam logic [CELL_W-1:0] BLUE  = 5'd18;
    localparam logic [CELL_W-1:0] DARK  = 5'd31;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FIRE     = 2'd1,
        COOLDOWN = 2'd2
    } fire_state_t;

    typedef enum logic [0:0] {
        NEUTRAL = 1'b0,
        HOLD    = 1'b1
    } move_state_t;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } dir_t;

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module   : btn_debounce
// Brief    : Two-flop synchronizer plus stable-count debouncer for a raw button.
// Revision : 1.0 - initial release
// ============================================================================
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic db
);

    localparam int                 c_CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic               r_s1;
    logic               r_s2;
    logic               r_db;
    logic [c_CNT_W-1:0] r_cnt;

    // The counter only advances while the synchronized level disagrees with
    // the debounced one, so any return to agreement restarts the window.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1  <= 1'b0;
            r_s2  <= 1'b0;
            r_db  <= 1'b0;
            r_cnt <= '0;
        end else begin
            r_s1 <= btn;
            r_s2 <= r_s1;
            if (r_s2 != r_db) begin
                if (r_cnt == c_CNT_MAX) begin
                    r_db  <= r_s2;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign db = r_db;

endmodule
`default_nettype wire

// File: rtl/bubble_shooter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bubble_shooter_ctrl
// Brief    : Joystick column pointer with auto-repeat and a debounced,
//            cooldown-guarded fire pulse for the bubble grid manager.
// Revision : 1.0 - initial release
// ============================================================================
module bubble_shooter_ctrl #(
    parameter int         NUM_COLS        = 8,
    parameter int         START_POS       = 3,
    parameter logic [9:0] X_LOW           = 10'd300,
    parameter logic [9:0] X_HIGH          = 10'd700,
    parameter int         DEBOUNCE_CYCLES = 100000,
    parameter int         REPEAT_CYCLES   = 25000000,
    parameter int         COOLDOWN_CYCLES = 10000000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [9:0]                    jstk_x,
    input  logic                          jstk_btn,
    output logic [bubble_pkg::COL_W-1:0]  shoot_pos,
    output logic                          fire,
    output logic                          busy
);

    import bubble_pkg::*;

    localparam int                 c_CD_W    = $clog2(COOLDOWN_CYCLES);
    localparam int                 c_REP_W   = $clog2(REPEAT_CYCLES);
    localparam logic [c_CD_W-1:0]  c_CD_MAX  = c_CD_W'(COOLDOWN_CYCLES - 1);
    localparam logic [c_REP_W-1:0] c_REP_MAX = c_REP_W'(REPEAT_CYCLES - 1);
    localparam logic [COL_W-1:0]   c_POS_MAX = COL_W'(NUM_COLS - 1);
    localparam logic [COL_W-1:0]   c_START   = COL_W'(START_POS);

    logic               w_db;
    logic               r_db_d;
    logic               w_press;
    logic [9:0]         r_x;
    dir_t               w_dir;

    fire_state_t        r_fire_state;
    fire_state_t        w_fire_next;
    logic [c_CD_W-1:0]  r_cd_cnt;
    logic [c_CD_W-1:0]  w_cd_next;

    move_state_t        r_move_state;
    move_state_t        w_move_next;
    dir_t               r_hold_dir;
    dir_t               w_hold_next;
    logic [c_REP_W-1:0] r_rep_cnt;
    logic [c_REP_W-1:0] w_rep_next;
    dir_t               w_step;
    logic               w_step_ok;

    logic [COL_W-1:0]   r_pos;
    logic [COL_W-1:0]   w_pos_next;
    logic               r_fire;
    logic               r_busy;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk (clk),
        .rst (rst),
        .btn (jstk_btn),
        .db  (w_db)
    );

    assign w_press = w_db & ~r_db_d;

    always_comb begin
        w_dir = NONE;
        if (r_x < X_LOW) begin
            w_dir = LEFT;
        end else if (r_x > X_HIGH) begin
            w_dir = RIGHT;
        end
    end

    always_comb begin
        w_fire_next = r_fire_state;
        w_cd_next   = r_cd_cnt;
        case (r_fire_state)
            IDLE: begin
                if (w_press && en) begin
                    w_fire_next = FIRE;
                end
            end
            FIRE: begin
                w_fire_next = COOLDOWN;
                w_cd_next   = c_CD_MAX;
            end
            COOLDOWN: begin
                if (r_cd_cnt == '0) begin
                    w_fire_next = IDLE;
                end else begin
                    w_cd_next = r_cd_cnt - 1'b1;
                end
            end
            default: begin
                w_fire_next = IDLE;
            end
        endcase
    end

    // A press that is about to fire takes priority, so the grid sees the
    // column as it was before any step in the same cycle.
    assign w_step_ok = en && (r_fire_state == IDLE) && !w_press;

    always_comb begin
        w_move_next = r_move_state;
        w_hold_next = r_hold_dir;
        w_rep_next  = r_rep_cnt;
        w_step      = NONE;
        if (!w_step_ok || w_dir == NONE) begin
            w_move_next = NEUTRAL;
            w_hold_next = NONE;
            w_rep_next  = '0;
        end else if (r_move_state == NEUTRAL || w_dir != r_hold_dir) begin
            w_step      = w_dir;
            w_move_next = HOLD;
            w_hold_next = w_dir;
            w_rep_next  = c_REP_MAX;
        end else if (r_rep_cnt == '0) begin
            w_step     = w_dir;
            w_rep_next = c_REP_MAX;
        end else begin
            w_rep_next = r_rep_cnt - 1'b1;
        end
    end

    always_comb begin
        w_pos_next = r_pos;
        if (w_step == LEFT && r_pos != '0) begin
            w_pos_next = r_pos - 1'b1;
        end else if (w_step == RIGHT && r_pos != c_POS_MAX) begin
            w_pos_next = r_pos + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x          <= '0;
            r_db_d       <= 1'b0;
            r_fire_state <= IDLE;
            r_cd_cnt     <= '0;
            r_move_state <= NEUTRAL;
            r_hold_dir   <= NONE;
            r_rep_cnt    <= '0;
            r_pos        <= c_START;
            r_fire       <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_x          <= jstk_x;
            r_db_d       <= w_db;
            r_fire_state <= w_fire_next;
            r_cd_cnt     <= w_cd_next;
            r_move_state <= w_move_next;
            r_hold_dir   <= w_hold_next;
            r_rep_cnt    <= w_rep_next;
            r_pos        <= w_pos_next;
            r_fire       <= (w_fire_next == FIRE);
            r_busy       <= (w_fire_next != IDLE);
        end
    end

    assign shoot_pos = r_pos;
    assign fire      = r_fire;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_bubble_shooter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bubble_shooter_ctrl
// Brief    : Scenario and randomized checks of bubble_shooter_ctrl against a
//            behavioural model of the column/fire rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bubble_shooter_ctrl;

    localparam int P_DB   = 4;
    localparam int P_REP  = 8;
    localparam int P_COOL = 6;
    localparam int P_COLS = 8;
    localparam int P_START = 3;

    logic       clk;
    logic       rst;
    logic       en;
    logic [9:0] jstk_x;
    logic       jstk_btn;
    logic [2:0] shoot_pos;
    logic       fire;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;

    // model state: button pipeline, debounced level, fire timing, movement
    bit m_s1, m_s2, m_db, m_db_d;
    int m_run, m_x, m_pos, m_busy_left, m_held, m_since;
    bit m_fire, m_busy;

    bubble_shooter_ctrl #(
        .NUM_COLS        (P_COLS),
        .START_POS       (P_START),
        .X_LOW           (10'd300),
        .X_HIGH          (10'd700),
        .DEBOUNCE_CYCLES (P_DB),
        .REPEAT_CYCLES   (P_REP),
        .COOLDOWN_CYCLES (P_COOL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .jstk_x    (jstk_x),
        .jstk_btn  (jstk_btn),
        .shoot_pos (shoot_pos),
        .fire      (fire),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (got timeout, want finish)");
        $fatal(1);
    end

    function automatic int clamp(input int v);
        return (v < 0) ? 0 : (v > P_COLS - 1) ? P_COLS - 1 : v;
    endfunction

    // Applies one clock edge of the rules using the inputs seen at that edge.
    task automatic model_edge();
        int  d;
        bit  press, idle, ok;
        if (rst) begin
            m_s1 = 0; m_s2 = 0; m_db = 0; m_db_d = 0; m_run = 0; m_x = 0;
            m_pos = P_START; m_busy_left = 0; m_held = 0; m_since = 0;
            m_fire = 0; m_busy = 0;
            return;
        end
        d     = (m_x < 300) ? -1 : (m_x > 700) ? 1 : 0;
        press = m_db && !m_db_d;
        idle  = (m_busy_left == 0);
        ok    = en && idle && !press;
        if (idle && press && en) begin
            m_busy_left = P_COOL + 1;
            m_fire      = 1;
        end else begin
            if (m_busy_left > 0) m_busy_left--;
            m_fire = 0;
        end
        m_busy = (m_busy_left > 0);
        if (!ok || d == 0) begin
            m_held = 0;
        end else if (d != m_held) begin
            m_pos = clamp(m_pos + d); m_held = d; m_since = 0;
        end else begin
            m_since++;
            if (m_since == P_REP) begin
                m_pos = clamp(m_pos + d); m_since = 0;
            end
        end
        m_db_d = m_db;
        if (m_s2 != m_db) begin
            m_run++;
            if (m_run == P_DB) begin m_db = m_s2; m_run = 0; end
        end else begin
            m_run = 0;
        end
        m_s2 = m_s1;
        m_s1 = jstk_btn;
        m_x  = jstk_x;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // en rises one edge after reset release so x_r holds a real joystick sample
    task automatic do_reset();
        rst = 1; en = 0; jstk_btn = 0; jstk_x = 10'd512;
        repeat (3) cyc();
        rst = 0;
        cyc();
        en = 1;
    endtask

    task automatic test_reset();
        rst = 1; en = 0; jstk_btn = 0; jstk_x = 10'd512;
        repeat (3) cyc();
        n_cmp++;
        if (shoot_pos !== 3'd3 || fire !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_values pos/fire/busy got %0d/%0b/%0b want 3/0/0", shoot_pos, fire, busy);
        end
        rst = 0;
        cyc();
        en = 1;
        for (int k = 0; k < 20; k++) begin
            cyc();
            n_cmp++;
            if (shoot_pos !== 3'd3 || fire !== 1'b0 || busy !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_idle k=%0d pos/fire/busy got %0d/%0b/%0b want 3/0/0", k, shoot_pos, fire, busy);
            end
        end
    endtask

    task automatic test_debounce_fire();
        int fire_at = -1, n_fires = 0, n_busy = 0, pos_bad = 0;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            jstk_btn = ((i / 2) % 2 == 0);
            cyc();
            n_cmp++;
            if ({shoot_pos, fire, busy} !== {3'(m_pos), m_fire, m_busy}) begin
                n_bad++;
                $display("FAIL bounce_model i=%0d pos/fire/busy got %0d/%0b/%0b want %0d/%0b/%0b", i, shoot_pos, fire, busy, m_pos, m_fire, m_busy);
            end
        end
        jstk_btn = 1;
        for (int k = 1; k <= 30; k++) begin
            cyc();
            if (fire) begin n_fires++; if (fire_at < 0) fire_at = k; end
            if (busy) n_busy++;
            if (shoot_pos !== 3'd3) pos_bad++;
        end
        n_cmp++;
        if (fire_at !== 7) begin n_bad++; $display("FAIL fire_latency got edge %0d want edge 7", fire_at); end
        n_cmp++;
        if (n_fires !== 1) begin n_bad++; $display("FAIL fire_count got %0d want 1", n_fires); end
        n_cmp++;
        if (n_busy !== 7) begin n_bad++; $display("FAIL busy_width got %0d want 7", n_busy); end
        n_cmp++;
        if (pos_bad !== 0) begin n_bad++; $display("FAIL fire_pos_stable got %0d bad cycles want 0", pos_bad); end
    endtask

    task automatic test_saturate_right();
        int exp;
        do_reset();
        jstk_x = 10'd900;
        for (int k = 1; k <= 40; k++) begin
            cyc();
            exp = (k < 2) ? 3 : (4 + (k - 2) / 8 > 7 ? 7 : 4 + (k - 2) / 8);
            n_cmp++;
            if (shoot_pos !== 3'(exp) || shoot_pos !== 3'(m_pos)) begin
                n_bad++;
                $display("FAIL right_repeat k=%0d pos got %0d want %0d (model %0d)", k, shoot_pos, exp, m_pos);
            end
        end
    endtask

    task automatic test_left_steps();
        do_reset();
        for (int s = 0; s < 3; s++) begin
            jstk_x = (s == 1) ? 10'd512 : 10'd100;
            repeat (3) begin
                cyc();
                n_cmp++;
                if ({shoot_pos, fire, busy} !== {3'(m_pos), m_fire, m_busy}) begin
                    n_bad++;
                    $display("FAIL left_model s=%0d pos/fire/busy got %0d/%0b/%0b want %0d/%0b/%0b", s, shoot_pos, fire, busy, m_pos, m_fire, m_busy);
                end
            end
        end
        n_cmp++;
        if (shoot_pos !== 3'd1) begin n_bad++; $display("FAIL left_two_steps pos got %0d want 1", shoot_pos); end
        jstk_x = 10'd300;
        repeat (12) cyc();
        n_cmp++;
        if (shoot_pos !== 3'd1) begin n_bad++; $display("FAIL x_low_exclusive pos got %0d want 1", shoot_pos); end
        jstk_x = 10'd700;
        repeat (12) cyc();
        n_cmp++;
        if (shoot_pos !== 3'd1) begin n_bad++; $display("FAIL x_high_exclusive pos got %0d want 1", shoot_pos); end
    endtask

    task automatic test_cooldown_freeze();
        bit got = 0;
        int first_idle = -1, n_fires = 0, pos_bad = 0;
        do_reset();
        jstk_btn = 1;
        for (int k = 1; k <= 20 && !got; k++) begin
            cyc();
            if (fire) got = 1;
        end
        n_cmp++;
        if (!got) begin n_bad++; $display("FAIL cd_first_fire got no pulse want pulse within 20 cycles"); end
        jstk_x = 10'd900;
        for (int k = 1; k <= 20; k++) begin
            jstk_btn = !(k == 1 || k == 2);
            cyc();
            if (fire) n_fires++;
            if (busy && shoot_pos !== 3'd3) pos_bad++;
            if (!busy && first_idle < 0) first_idle = k;
            if (k == first_idle + 1) begin
                n_cmp++;
                if (shoot_pos !== 3'd4) begin n_bad++; $display("FAIL cd_step_after pos got %0d want 4", shoot_pos); end
            end
            n_cmp++;
            if ({shoot_pos, fire, busy} !== {3'(m_pos), m_fire, m_busy}) begin
                n_bad++;
                $display("FAIL cd_model k=%0d pos/fire/busy got %0d/%0b/%0b want %0d/%0b/%0b", k, shoot_pos, fire, busy, m_pos, m_fire, m_busy);
            end
        end
        n_cmp++;
        if (first_idle !== 7) begin n_bad++; $display("FAIL cd_busy_end got %0d want 7", first_idle); end
        n_cmp++;
        if (n_fires !== 0 || pos_bad !== 0) begin
            n_bad++; $display("FAIL cd_no_fire_frozen fires/bad got %0d/%0d want 0/0", n_fires, pos_bad);
        end
    endtask

    task automatic test_enable_and_reset();
        int n_fires = 0, pos_bad = 0;
        bit got = 0;
        do_reset();
        en = 0; jstk_btn = 1; jstk_x = 10'd900;
        repeat (30) begin
            cyc();
            if (fire || busy) n_fires++;
            if (shoot_pos !== 3'd3) pos_bad++;
        end
        n_cmp++;
        if (n_fires !== 0 || pos_bad !== 0) begin
            n_bad++; $display("FAIL en_block fire/busy/bad got %0d/%0d want 0/0", n_fires, pos_bad);
        end
        jstk_btn = 0; jstk_x = 10'd512;
        repeat (12) cyc();
        en = 1; jstk_x = 10'd900;
        for (int k = 1; k <= 30 && shoot_pos != 3'd5; k++) cyc();
        jstk_x = 10'd512;
        n_cmp++;
        if (shoot_pos !== 3'd5) begin n_bad++; $display("FAIL rst_setup pos got %0d want 5", shoot_pos); end
        jstk_btn = 1;
        for (int k = 1; k <= 20 && !got; k++) begin
            cyc();
            if (fire) got = 1;
        end
        repeat (2) cyc();
        n_cmp++;
        if (busy !== 1'b1) begin n_bad++; $display("FAIL rst_in_cooldown busy got %0b want 1", busy); end
        rst = 1;
        cyc();
        n_cmp++;
        if (shoot_pos !== 3'd3 || fire !== 1'b0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL rst_abort pos/fire/busy got %0d/%0b/%0b want 3/0/0", shoot_pos, fire, busy);
        end
        rst = 0;
    endtask

    task automatic test_random();
        int xs[11] = '{0, 100, 299, 300, 301, 512, 699, 700, 701, 900, 1023};
        int x_hold = 0, b_hold = 0;
        do_reset();
        for (int t = 0; t < 1500; t++) begin
            if (x_hold == 0) begin
                jstk_x = ($urandom_range(0, 5) == 0) ? 10'($urandom_range(0, 1023)) : 10'(xs[$urandom_range(0, 10)]);
                x_hold = $urandom_range(1, 20);
            end
            x_hold--;
            if (b_hold == 0) begin
                jstk_btn = ~jstk_btn;
                b_hold = $urandom_range(1, 12);
            end
            b_hold--;
            en  = ($urandom_range(0, 9) != 0);
            rst = ($urandom_range(0, 199) == 0);
            cyc();
            n_cmp++;
            if ({shoot_pos, fire, busy} !== {3'(m_pos), m_fire, m_busy}) begin
                n_bad++;
                $display("FAIL random t=%0d pos/fire/busy got %0d/%0b/%0b want %0d/%0b/%0b", t, shoot_pos, fire, busy, m_pos, m_fire, m_busy);
            end
        end
        rst = 0;
    endtask

    initial begin
        rst = 1; en = 0; jstk_btn = 0; jstk_x = 10'd512;
        test_reset();
        test_debounce_fire();
        test_saturate_right();
        test_left_steps();
        test_cooldown_freeze();
        test_enable_and_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bubble_shooter_ctrl.md
Name: bubble_shooter_ctrl

Overview:
Joystick-side initiator for the bubble grid manager. Turns the raw PmodJSTK X-axis value and button into a saturating column pointer (shoot_pos, 0..7) and a one-cycle fire pulse. The fire pulse drives the grid manager's press input, and its pop logic reads shoot_pos. Handles button synchronisation and debouncing, auto-repeat column stepping, and a post-fire cooldown that keeps shoot_pos stable while the grid manager consumes it.

Parameters:
NUM_COLS, 8, number of grid columns; shoot_pos saturates at NUM_COLS-1
START_POS, 3, shoot_pos value after reset
X_LOW, 10'd300, jstk_x below this = left deflection
X_HIGH, 10'd700, jstk_x above this = right deflection
DEBOUNCE_CYCLES, 100000, consecutive stable cycles before debounced button changes (>=2)
REPEAT_CYCLES, 25000000, cycles between auto-repeat steps while deflection held (>=2)
COOLDOWN_CYCLES, 10000000, cycles busy stays high after a fire pulse (>=2)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
en  in  1  game running; 0 blocks fire and movement
jstk_x  in  10  joystick X value, already synchronous to clk (512 = centre)
jstk_btn  in  1  raw joystick button, asynchronous and bouncy
shoot_pos  out  3  current target column, registered
fire  out  1  one-cycle fire pulse, registered; connects to the grid manager's press input
busy  out  1  high in FIRE and COOLDOWN

Behaviour:
- Reset: shoot_pos=START_POS, fire=0, busy=0, fire FSM=IDLE, move FSM=NEUTRAL, sync/debounced/x registers=0, all counters=0. Reset mid-cooldown or mid-repeat aborts immediately.
- Button path: 2-flop synchronizer gives s2. The debounce counter increments each cycle s2 != db and clears when s2 == db. When the counter reaches DEBOUNCE_CYCLES-1 while still differing, db <= s2 and the counter clears. A glitch shorter than DEBOUNCE_CYCLES never changes db.
- press_edge = db rising (db & ~db_d).
- Fire FSM:
  - IDLE -> FIRE on press_edge & en.
  - FIRE: fire=1 for exactly this cycle, busy=1, then -> COOLDOWN and load the cooldown counter.
  - COOLDOWN: busy=1 for COOLDOWN_CYCLES cycles, then -> IDLE. press_edge is ignored; it is not queued.
  - en dropping in FIRE/COOLDOWN does not abort the sequence.
- Latency: fire asserts exactly 3+DEBOUNCE_CYCLES clock edges after the first edge that samples jstk_btn=1, given btn stays stable.
- Direction: x_r <= jstk_x each cycle. dir = LEFT if x_r<X_LOW, RIGHT if x_r>X_HIGH, else NONE. X_LOW and X_HIGH are exclusive bounds.
- Move FSM:
  - NEUTRAL: when dir!=NONE and step allowed, step once on the next edge, load the repeat counter, -> HOLD(dir).
  - HOLD: each time the repeat counter expires (REPEAT_CYCLES cycles) with the same dir, step and reload.
  - dir -> NONE returns to NEUTRAL.
  - dir reversing directly (LEFT <-> RIGHT) counts as a new deflection: immediate step, counter reloaded.
- Step: LEFT decrements, RIGHT increments. Saturates at 0 and NUM_COLS-1 with no wrap; a saturated step leaves shoot_pos unchanged.
- Step allowed only when en=1 and fire FSM=IDLE. shoot_pos is frozen in FIRE and COOLDOWN, so it is stable in the fire cycle and the following cycle.
- While not allowed, the move FSM is held in NEUTRAL. A deflection still held when stepping becomes allowed gives an immediate step on the next edge.
- Simultaneous press_edge and step-eligible deflection in IDLE: fire wins. FIRE is entered and no step occurs that cycle; fire uses the pre-step shoot_pos.
- Counter widths are $clog2 of their parameter. No arithmetic overflow is possible.

Decomposition:
- Shared package bubble_pkg holds:
  - NUM_COLS, COL_W=3, CELL_W=5
  - colour codes RED=16, GREEN=17, BLUE=18, DARK=31
  - fire state enum {IDLE, FIRE, COOLDOWN}
  - move state enum {NEUTRAL, HOLD}
  - direction enum {NONE, LEFT, RIGHT}
- One sub-module: btn_debounce (2-flop synchronizer + debounce counter, parameter DEBOUNCE_CYCLES, output db). The FSMs stay in the top module.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8, COOLDOWN_CYCLES=6.
1. Reset released, jstk_x=512, btn=0 -> shoot_pos=3, fire=0, busy=0 for 20 cycles.
2. btn toggles every 2 cycles for 12 cycles, then held high -> exactly one fire pulse, 1 cycle wide, 7 edges after the stable high begins; busy high 7 cycles total; shoot_pos=3 throughout.
3. jstk_x=900 held 40 cycles -> shoot_pos 4 one edge after x_r updates, then 5, 6, 7 at 8-cycle intervals, then stays 7 (saturation).
4. jstk_x=100 for 3 cycles, then 512 for 3 cycles, then 100 for 3 cycles -> shoot_pos 3->2->1, one step per deflection; jstk_x=300 exactly -> no step.
5. Fire, then second press during COOLDOWN plus jstk_x=900 -> no second fire; shoot_pos unchanged until busy falls, then steps to 4 on the next edge.
6. en=0 with press and jstk_x=900 -> no fire, no move. Separately, rst asserted mid-COOLDOWN with shoot_pos=5 -> next edge busy=0, fire=0, shoot_pos=3.
